// File: rtl/fetch_control_if.sv
// Fetch-stage bus: instruction-memory port, redirect/halt controls and the
// decoupled instruction output toward decode.
//   master : fetch_control side (drives imem_pc, out_*, state)
//   slave  : environment side (memory, branch unit, decode)
interface fetch_control_if;
    localparam int unsigned PC_W    = 16;
    localparam int unsigned INSTR_W = 16;

    logic [PC_W-1:0]    imem_pc;
    logic [INSTR_W-1:0] imem_instr;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               halt;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [1:0]         state;

    modport master (
        output imem_pc, out_valid, out_instr, out_pc, state,
        input  imem_instr, redirect_valid, redirect_pc, halt, out_ready
    );

    modport slave (
        input  imem_pc, out_valid, out_instr, out_pc, state,
        output imem_instr, redirect_valid, redirect_pc, halt, out_ready
    );
endinterface

// File: rtl/fetch_control.sv
// Instruction fetch controller with a 2-entry {pc, instr} output buffer.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : fetch_control_if.master (imem port, redirect/halt, out handshake, state)
module fetch_control #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_LIMIT = 16'h01FE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fetch_control_if.master        bus
);
    localparam int unsigned PC_W    = 16;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned CNT_W   = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_STALL  = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    imem_pc_q, imem_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PC_W-1:0]    pc0_q, pc0_d, pc1_q, pc1_d;
    logic [INSTR_W-1:0] instr0_q, instr0_d, instr1_q, instr1_d;

    logic               pop_c;
    logic               push_c;
    logic               full_c;
    logic               redirect_c;
    logic [CNT_W-1:0]   count_after_pop_c;

    // State register and buffer storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            imem_pc_q <= RESET_PC;
            count_q   <= '0;
            pc0_q     <= '0;
            pc1_q     <= '0;
            instr0_q  <= '0;
            instr1_q  <= '0;
        end else begin
            state_q   <= state_d;
            imem_pc_q <= imem_pc_d;
            count_q   <= count_d;
            pc0_q     <= pc0_d;
            pc1_q     <= pc1_d;
            instr0_q  <= instr0_d;
            instr1_q  <= instr1_d;
        end
    end

    // Next-state, fetch-address and buffer update
    always_comb begin
        state_d           = state_q;
        imem_pc_d         = imem_pc_q;
        count_d           = count_q;
        pc0_d             = pc0_q;
        pc1_d             = pc1_q;
        instr0_d          = instr0_q;
        instr1_d          = instr1_q;
        push_c            = 1'b0;
        full_c            = (count_q == CNT_W'(2));
        pop_c             = (count_q != '0) && bus.out_ready;
        redirect_c        = bus.redirect_valid && (state_q != S_IDLE);
        count_after_pop_c = count_q - CNT_W'(pop_c);

        if (redirect_c) begin
            // Redirect wins over halt; any pending transfer still completes.
            state_d   = S_FETCH;
            imem_pc_d = bus.redirect_pc & ~PC_W'(1);
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_FETCH;
                S_FETCH: begin
                    if (bus.halt) begin
                        state_d = S_HALTED;
                    end else if (!full_c || pop_c) begin
                        push_c = 1'b1;
                    end else begin
                        state_d = S_STALL;
                    end
                end
                S_STALL: begin
                    if (bus.halt) begin
                        state_d = S_HALTED;
                    end else if (pop_c) begin
                        // Same imem_pc is presented again in FETCH next cycle.
                        state_d = S_FETCH;
                    end
                end
                S_HALTED: state_d = S_HALTED;
                default:  state_d = S_IDLE;
            endcase
        end

        if (push_c) begin
            imem_pc_d = (imem_pc_q == PC_LIMIT) ? RESET_PC : imem_pc_q + PC_W'(2);
        end

        // Head is always entry 0; a pop shifts entry 1 forward.
        if (pop_c) begin
            pc0_d    = pc1_q;
            instr0_d = instr1_q;
        end
        if (push_c) begin
            if (count_after_pop_c == '0) begin
                pc0_d    = imem_pc_q;
                instr0_d = bus.imem_instr;
            end else begin
                pc1_d    = imem_pc_q;
                instr1_d = bus.imem_instr;
            end
        end
        count_d = redirect_c ? '0 : count_after_pop_c + CNT_W'(push_c);
    end

    assign bus.imem_pc   = imem_pc_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_instr = instr0_q;
    assign bus.out_pc    = pc0_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control: startup, stall, redirect, wrap, halt, reset.
module tb_fetch_control;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [15:0] mem [256];

    fetch_control_if bus ();

    fetch_control #(
        .RESET_PC (16'h0000),
        .PC_LIMIT (16'h01FE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.imem_instr = mem[bus.imem_pc[8:1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ends one cycle after the reset edge with rst_n high (cycle 0, IDLE).
    task automatic do_reset();
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        bus.halt           = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 273 + 8192);
        mem[0] = 16'h1000;
        mem[1] = 16'h1442;
        mem[2] = 16'h3050;

        rst_n              = 1'b0;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0040;
        bus.halt           = 1'b1;
        tick();
        tick();
        // Reset values while rst_n is low (redirect/halt ignored)
        check_eq("rst_state", {14'b0, bus.state}, 16'd0);
        check_eq("rst_valid", {15'b0, bus.out_valid}, 16'd0);
        check_eq("rst_pc", bus.imem_pc, 16'h0000);
        check_eq("rst_out_instr", bus.out_instr, 16'h0000);
        check_eq("rst_out_pc", bus.out_pc, 16'h0000);

        // Startup with out_ready=1
        do_reset();
        check_eq("c0_state_idle", {14'b0, bus.state}, 16'd0);
        tick();
        check_eq("c1_state_fetch", {14'b0, bus.state}, 16'd1);
        check_eq("c1_valid", {15'b0, bus.out_valid}, 16'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("start_valid", {15'b0, bus.out_valid}, 16'd1);
            check_eq("start_pc", bus.out_pc, 16'(2 * k));
            check_eq("start_instr", bus.out_instr, mem[k]);
        end

        // Backpressure: out_ready=0 for 4 cycles after the first fetch
        do_reset();
        bus.out_ready = 1'b0;
        tick(); tick(); tick(); tick();
        check_eq("stall_state", {14'b0, bus.state}, 16'd2);
        check_eq("stall_head_pc", bus.out_pc, 16'h0000);
        check_eq("stall_imem_pc", bus.imem_pc, 16'h0004);
        tick();
        check_eq("stall_state2", {14'b0, bus.state}, 16'd2);
        check_eq("stall_imem_pc2", bus.imem_pc, 16'h0004);
        check_eq("stall_hold_pc", bus.out_pc, 16'h0000);
        check_eq("stall_hold_instr", bus.out_instr, 16'h1000);
        bus.out_ready = 1'b1;
        check_eq("drain0_pc", bus.out_pc, 16'h0000);
        tick();
        check_eq("drain1_pc", bus.out_pc, 16'h0002);
        check_eq("drain1_instr", bus.out_instr, 16'h1442);
        check_eq("drain1_state", {14'b0, bus.state}, 16'd1);
        tick();
        check_eq("drain2_pc", bus.out_pc, 16'h0004);
        check_eq("drain2_instr", bus.out_instr, 16'h3050);
        tick();
        check_eq("drain3_pc", bus.out_pc, 16'h0006);

        // Redirect while the buffer holds two entries
        do_reset();
        bus.out_ready = 1'b0;
        tick(); tick(); tick();
        check_eq("full_head_pc", bus.out_pc, 16'h0000);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0019;
        tick();
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        check_eq("redir_valid", {15'b0, bus.out_valid}, 16'd0);
        check_eq("redir_imem_pc", bus.imem_pc, 16'h0018);
        check_eq("redir_state", {14'b0, bus.state}, 16'd1);
        tick();
        check_eq("redir_out_pc", bus.out_pc, 16'h0018);
        check_eq("redir_out_instr", bus.out_instr, mem[12]);

        // Redirect to the last address, then wrap
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h01FE;
        tick();
        bus.redirect_valid = 1'b0;
        check_eq("wrap_flush", {15'b0, bus.out_valid}, 16'd0);
        tick();
        check_eq("wrap_pc_last", bus.out_pc, 16'h01FE);
        check_eq("wrap_instr_last", bus.out_instr, mem[255]);
        tick();
        check_eq("wrap_pc_zero", bus.out_pc, 16'h0000);
        check_eq("wrap_instr_zero", bus.out_instr, 16'h1000);

        // Halt with one buffered entry: it drains, fetch stays frozen
        bus.halt      = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.halt = 1'b0;
        check_eq("halt_state", {14'b0, bus.state}, 16'd3);
        check_eq("halt_keep_valid", {15'b0, bus.out_valid}, 16'd1);
        check_eq("halt_keep_pc", bus.out_pc, 16'h0000);
        check_eq("halt_imem_pc", bus.imem_pc, 16'h0002);
        bus.out_ready = 1'b1;
        tick();
        check_eq("halt_drained", {15'b0, bus.out_valid}, 16'd0);
        tick();
        check_eq("halt_stay", {14'b0, bus.state}, 16'd3);
        check_eq("halt_frozen_pc", bus.imem_pc, 16'h0002);
        bus.halt           = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0010;
        tick();
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        check_eq("unhalt_state", {14'b0, bus.state}, 16'd1);
        tick();
        check_eq("unhalt_valid", {15'b0, bus.out_valid}, 16'd1);
        check_eq("unhalt_pc", bus.out_pc, 16'h0010);
        check_eq("unhalt_instr", bus.out_instr, mem[8]);

        // Reset pulse during STALL
        do_reset();
        bus.out_ready = 1'b0;
        tick(); tick(); tick(); tick();
        check_eq("pre_rst_stall", {14'b0, bus.state}, 16'd2);
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0080;
        tick();
        rst_n              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        check_eq("mid_rst_state", {14'b0, bus.state}, 16'd0);
        check_eq("mid_rst_valid", {15'b0, bus.out_valid}, 16'd0);
        check_eq("mid_rst_instr", bus.out_instr, 16'h0000);
        check_eq("mid_rst_out_pc", bus.out_pc, 16'h0000);
        check_eq("mid_rst_imem_pc", bus.imem_pc, 16'h0000);
        tick();
        tick();
        check_eq("restart_pc", bus.out_pc, 16'h0000);
        check_eq("restart_instr", bus.out_instr, 16'h1000);
        check_eq("restart_valid", {15'b0, bus.out_valid}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_control.md
FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the byte address fetched first after reset.
REQ-002 SHALL have parameter PC_LIMIT, default 16'h01FE, meaning the last valid instruction byte address (256 words x 2 bytes).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning the reset, synchronous and active-low.
REQ-005 SHALL have port imem_pc  output  16  meaning the byte address driven to the instruction memory (word index = imem_pc[8:1]).
REQ-006 SHALL have port imem_instr  input  16  meaning the combinational read data for imem_pc, valid in the same cycle.
REQ-007 SHALL have port redirect_valid  input  1  meaning a branch/jump target is present this cycle.
REQ-008 SHALL have port redirect_pc  input  16  meaning the target byte address; bit 0 is ignored and treated as 0.
REQ-009 SHALL have port halt  input  1  meaning stop fetching after the current cycle.
REQ-010 SHALL have port out_valid  output  1  meaning out_instr/out_pc hold a fetched instruction.
REQ-011 SHALL have port out_ready  input  1  meaning the decode stage accepts the presented instruction.
REQ-012 SHALL have port out_instr  output  16  meaning the instruction at the buffer head.
REQ-013 SHALL have port out_pc  output  16  meaning the byte address of out_instr.
REQ-014 SHALL have port state  output  2  meaning FSM encoding: 0 IDLE, 1 FETCH, 2 STALL, 3 HALTED.

Function
REQ-015 SHALL hold a 2-entry FIFO of {pc, instr} pairs; out_instr/out_pc are the head entry; out_valid = FIFO non-empty.
REQ-016 SHALL count a transfer only in cycles where out_valid and out_ready are both 1; the head is then popped.
REQ-017 SHALL leave IDLE for FETCH unconditionally in the first cycle after rst_n returns high.
REQ-018 SHALL, in FETCH, write {imem_pc, imem_instr} into the FIFO at the clock edge if the FIFO is not full or a transfer occurs that cycle, then advance imem_pc.
REQ-019 SHALL advance imem_pc by 2; when the fetched address equals PC_LIMIT, the next imem_pc SHALL be RESET_PC (wrap).
REQ-020 SHALL give 1-cycle latency: an instruction fetched in cycle N appears with out_valid=1 in cycle N+1; throughput one instruction per cycle while out_ready=1.
REQ-021 SHALL enter STALL when the FIFO is full with no transfer; imem_pc SHALL stay constant; FIFO contents SHALL not change.
REQ-022 SHALL return from STALL to FETCH in the cycle after a transfer, re-presenting the same imem_pc (no instruction skipped or duplicated).
REQ-023 SHALL, on redirect_valid=1 in any non-IDLE state, flush the FIFO, load imem_pc with {redirect_pc[15:1],1'b0}, and go to FETCH at the next edge; out_valid SHALL be 0 in the following cycle.
REQ-024 SHALL complete a transfer that coincides with redirect_valid, then flush; no instruction fetched in that cycle SHALL enter the FIFO.
REQ-025 SHALL, on halt=1 without redirect, stop writing the FIFO and go to HALTED; buffered entries SHALL still drain through the handshake.
REQ-026 SHALL give redirect priority over halt when both are asserted in the same cycle.
REQ-027 SHALL stay in HALTED, with imem_pc frozen, until redirect_valid=1.
REQ-028 SHALL hold out_instr and out_pc stable while out_valid=1 and out_ready=0.

Reset
REQ-029 SHALL, while rst_n=0 at a clock edge, set state=IDLE, imem_pc=RESET_PC, FIFO empty, out_valid=0, out_instr=16'h0000, out_pc=16'h0000.
REQ-030 SHALL discard all in-flight state when reset is asserted mid-operation, including in STALL or HALTED, and ignore redirect_valid/halt in that cycle.

Verification
REQ-031 SHALL cover reset release with out_ready=1 and memory[0..2]=16'h1000,16'h1442,16'h3050 -> out_valid=1 from cycle 2; out_pc 0,2,4 on consecutive cycles; out_instr matches.
REQ-032 SHALL cover out_ready=0 for 4 cycles after first fetch -> state=STALL; FIFO holds pcs 0 and 2; imem_pc=4 frozen; after out_ready=1, pcs 0,2,4 each delivered exactly once.
REQ-033 SHALL cover redirect_valid=1 with redirect_pc=16'h0019 while the FIFO holds 2 entries -> next cycle out_valid=0, imem_pc=16'h0018; the cycle after, out_pc=16'h0018.
REQ-034 SHALL cover redirect to 16'h01FE -> out_pc sequence 16'h01FE then 16'h0000 (wrap).
REQ-035 SHALL cover halt=1 with the FIFO holding 1 entry -> that entry drains, then out_valid=0, state=3; asserting halt and redirect_pc=16'h0010 together -> state=1, out_pc=16'h0010 one cycle later.
REQ-036 SHALL cover rst_n=0 for one cycle during STALL -> outputs match REQ-029 next cycle; fetch restarts at RESET_PC.
